// File: rtl/psum_drain.sv
// Drain stage for the PE-array output buffer: reads a programmed number of
// 33-bit psums, saturates them to 16 bits, applies optional ReLU and streams them out.
module psum_drain #(
  parameter int PSUM_WIDTH = 33,
  parameter int OUT_WIDTH  = 16,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  out_count,
  input  logic                  relu_en,
  input  logic                  outbuf_empty,
  output logic                  outbuf_ren,
  input  logic [PSUM_WIDTH-1:0] outbuf_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPT,
    HOLD
  } state_t;

  // Clip bounds expressed at psum width so the compare stays signed end to end.
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   remaining;
  logic                   relu_q;
  logic                   handshake;
  logic                   last_word;

  logic signed [PSUM_WIDTH-1:0] psum;
  logic signed [OUT_WIDTH-1:0]  sat_val;
  logic [OUT_WIDTH-1:0]         result;
  logic                         clip;

  assign psum      = signed'(outbuf_dout);
  assign handshake = m_valid && m_ready;
  assign last_word = (remaining == CNT_WIDTH'(1));
  assign busy      = (state != IDLE);

  // Saturation first, ReLU second: ReLU zeroing is never counted as clipping.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the block can infer a latch.
    clip    = 1'b0;
    sat_val = psum[OUT_WIDTH-1:0];
    if (psum > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_WIDTH-1:0];
      clip    = 1'b1;
    end else if (psum < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_WIDTH-1:0];
      clip    = 1'b1;
    end
    result = sat_val;
    if (relu_q && sat_val[OUT_WIDTH-1]) begin
      result = '0;
    end
  end

  // Read strobe only in REQ, so at most one FIFO word is ever in flight.
  always_comb begin
    state_nxt  = state;
    outbuf_ren = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (out_count != '0)) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (!outbuf_empty) begin
          outbuf_ren = 1'b1;
          state_nxt  = CAPT;
        end
      end
      CAPT: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          state_nxt = last_word ? IDLE : REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      relu_q    <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register sees pre-edge values of the others.
      state <= state_nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sat_flag <= 1'b0;
            if (out_count == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= out_count;
              relu_q    <= relu_en;
            end
          end
        end
        CAPT: begin
          m_data  <= result;
          m_valid <= 1'b1;
          m_last  <= last_word;
          if (clip) begin
            sat_flag <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            remaining <= remaining - CNT_WIDTH'(1);
            if (last_word) begin
              done <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: a FIFO model, a behavioural reference
// (saturate/ReLU by plain arithmetic) checked every cycle, plus directed scenarios.
module tb_psum_drain;

  localparam int PW = 33;
  localparam int OW = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] out_count = '0;
  logic          relu_en = 1'b0;
  logic          outbuf_empty = 1'b1;
  logic          outbuf_ren;
  logic [PW-1:0] outbuf_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          sat_flag;

  psum_drain #(.PSUM_WIDTH(PW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .out_count(out_count), .relu_en(relu_en),
    .outbuf_empty(outbuf_empty), .outbuf_ren(outbuf_ren), .outbuf_dout(outbuf_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  longint    fifo_q[$];
  longint    psum_mem[$];
  logic [15:0] obs_q[$];
  bit        stall = 1'b0;
  bit        rnd_en = 1'b0;

  bit        model_busy = 1'b0;
  bit        model_done = 1'b0;
  bit        model_sat = 1'b0;
  bit        model_relu = 1'b0;
  bit        pop_req = 1'b0;
  int        model_rem = 0;
  int        rd_idx = 0;
  int        ren_total = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out(input longint v, input bit relu);
    longint r;
    if (v > 32767) r = 32767;
    else if (v < -32768) r = -32768;
    else r = v;
    if (relu && r < 0) r = 0;
    return 16'(r);
  endfunction

  function automatic bit model_clip(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic longint rand_psum();
    longint r;
    case ($urandom_range(0, 3))
      0: r = longint'($urandom_range(0, 60000)) - 30000;
      1: begin
        r = longint'($urandom);
        if ($urandom_range(0, 1) == 1) r = -r - 1;
      end
      2: begin
        case ($urandom_range(0, 5))
          0: r = 32767;
          1: r = 32768;
          2: r = -32768;
          3: r = -32769;
          4: r = 0;
          default: r = -1;
        endcase
      end
      default: r = ($urandom_range(0, 1) == 1) ? 64'sd4294967295 : -64'sd4294967296;
    endcase
    return r;
  endfunction

  // Reference model and per-cycle comparison, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      model_busy = 1'b0;
      model_done = 1'b0;
      model_sat  = 1'b0;
      model_rem  = 0;
      pop_req    = 1'b0;
      rd_idx     = psum_mem.size();
    end else begin
      pop_req = outbuf_ren;
      check("busy", busy, model_busy);
      check("done", done, model_done);
      if (outbuf_ren) begin
        ren_total++;
        check("ren_legal", (!outbuf_empty && !m_valid && model_busy), 1);
      end
      if (m_valid) begin
        check("valid_while_busy", model_busy, 1);
        check("word_available", psum_mem.size() > rd_idx, 1);
        if (rd_idx < psum_mem.size()) begin
          check("m_data", m_data, model_out(psum_mem[rd_idx], model_relu));
          check("m_last", m_last, model_rem == 1);
          check("sat_flag", sat_flag, model_sat || model_clip(psum_mem[rd_idx]));
        end
      end else if (!model_busy) begin
        check("sat_flag_idle", sat_flag, model_sat);
      end
      model_done = 1'b0;
      if (start && !model_busy) begin
        model_sat = 1'b0;
        if (out_count == 0) begin
          model_done = 1'b1;
        end else begin
          model_busy = 1'b1;
          model_rem  = out_count;
          model_relu = relu_en;
        end
      end
      if (m_valid && m_ready && model_busy && rd_idx < psum_mem.size()) begin
        obs_q.push_back(m_data);
        model_sat = model_sat | model_clip(psum_mem[rd_idx]);
        rd_idx++;
        model_rem--;
        if (model_rem == 0) begin
          model_busy = 1'b0;
          model_done = 1'b1;
        end
      end
    end
  end

  // One clock of stimulus: FIFO read data, optional random backpressure/stalls/stray starts.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_req && fifo_q.size() > 0) outbuf_dout = PW'(fifo_q.pop_front());
    else outbuf_dout = PW'({$urandom(), $urandom()});
    if (rnd_en) begin
      m_ready = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      if (model_busy && $urandom_range(0, 7) == 0) begin
        start     = 1'b1;
        out_count = CW'($urandom);
        relu_en   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    outbuf_empty = stall || (fifo_q.size() == 0);
  endtask

  task automatic push_word(input longint v);
    fifo_q.push_back(v);
    psum_mem.push_back(v);
    outbuf_empty = stall || (fifo_q.size() == 0);
  endtask

  task automatic wait_drain(input int n, input int ren0);
    int c;
    c = 0;
    while (model_busy && c < 3000) begin
      tick();
      c++;
    end
    check("drain_timeout", model_busy, 0);
    start   = 1'b0;
    m_ready = 1'b1;
    stall   = 1'b0;
    tick();
    tick();
    check("ren_pulses", ren_total - ren0, n);
  endtask

  task automatic do_drain(input int n, input bit relu, input bit junk);
    int ren0;
    ren0      = ren_total;
    out_count = CW'(n);
    relu_en   = relu;
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (junk) begin
      tick();
      start     = 1'b1;
      out_count = CW'(n + 4);
      relu_en   = ~relu;
      tick();
      start = 1'b0;
    end
    wait_drain(n, ren0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0]  probe_ren;
    logic [5:0]  probe_v;
    logic [15:0] nom_exp [5];
    int          ren0;
    int          obs0;
    int          c;
    int          n;
    bit          relu;

    probe_ren = 6'b001001;
    probe_v   = 6'b100100;
    nom_exp   = '{16'hFEA6, 16'h0333, 16'hFF65, 16'hFCF8, 16'h01EE};

    check("pin_neg", model_out(-346, 0), 16'hFEA6);
    check("pin_hi", model_out(40000, 0), 16'h7FFF);
    check("pin_lo", model_out(-40000, 0), 16'h8000);
    check("pin_relu", model_out(-346, 1), 0);
    check("pin_clip", model_clip(32768), 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ren", outbuf_ren, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
    rst = 1'b1;
    tick();

    // Nominal drain with cycle-exact latency/throughput probe.
    push_word(-346); push_word(819); push_word(-155); push_word(-776); push_word(494);
    ren0 = ren_total;
    out_count = 5;
    relu_en   = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("probe_ren", outbuf_ren, probe_ren[i]);
      check("probe_valid", m_valid, probe_v[i]);
      tick();
    end
    wait_drain(5, ren0);
    check("nom_count", obs_q.size(), 5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) check("nom_data", obs_q[i], nom_exp[i]);
    check("nom_sat", sat_flag, 0);

    // Saturation: flag set and sticky past done.
    push_word(40000); push_word(-40000); push_word(32767);
    do_drain(3, 0, 0);
    check("sat_sticky", sat_flag, 1);
    if (obs_q.size() >= 8) begin
      check("sat_d0", obs_q[5], 16'h7FFF);
      check("sat_d1", obs_q[6], 16'h8000);
      check("sat_d2", obs_q[7], 16'h7FFF);
    end

    // ReLU; the new start also clears the sticky flag.
    push_word(-346); push_word(819);
    do_drain(2, 1, 0);
    check("relu_sat", sat_flag, 0);
    if (obs_q.size() >= 10) begin
      check("relu_d0", obs_q[8], 0);
      check("relu_d1", obs_q[9], 16'h0333);
    end

    // Backpressure in HOLD.
    push_word(1234); push_word(-5);
    ren0 = ren_total;
    m_ready   = 1'b0;
    out_count = 2;
    relu_en   = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!m_valid && c < 20) begin tick(); c++; end
    check("bp_valid_seen", m_valid, 1);
    repeat (4) begin
      tick();
      @(negedge clk);
      check("bp_hold_data", m_data, 1234);
      check("bp_hold_last", m_last, 0);
      check("bp_no_ren", outbuf_ren, 0);
    end
    m_ready = 1'b1;
    wait_drain(2, ren0);

    // Empty stall in REQ.
    push_word(777);
    stall = 1'b1;
    outbuf_empty = 1'b1;
    ren0 = ren_total;
    out_count = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("stall_no_ren", outbuf_ren, 0);
      tick();
    end
    stall = 1'b0;
    outbuf_empty = (fifo_q.size() == 0);
    @(negedge clk);
    check("stall_resume_ren", outbuf_ren, 1);
    wait_drain(1, ren0);

    // Zero count.
    ren0 = ren_total;
    out_count = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    tick();
    @(negedge clk);
    check("zero_done_once", done, 0);
    check("zero_no_ren", ren_total - ren0, 0);

    // Start pulsed mid-drain is ignored.
    obs0 = obs_q.size();
    push_word(100); push_word(-100); push_word(50000);
    do_drain(3, 0, 1);
    check("ignored_start_results", obs_q.size() - obs0, 3);

    // Reset during HOLD of result 2 of 5.
    for (int i = 0; i < 5; i++) push_word(1000 + i);
    m_ready   = 1'b0;
    out_count = 5;
    start     = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!m_valid && c < 20) begin tick(); c++; end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    c = 0;
    while (!m_valid && c < 20) begin tick(); c++; end
    check("rst_second_valid", m_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ren", outbuf_ren, 0);
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_last", m_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sat", sat_flag, 0);
    tick();
    tick();
    rst = 1'b1;
    fifo_q.delete();
    outbuf_empty = 1'b1;
    m_ready = 1'b1;
    tick();
    obs0 = obs_q.size();
    push_word(-1); push_word(70000);
    do_drain(2, 0, 0);
    check("post_rst_results", obs_q.size() - obs0, 2);

    // Randomized drains with backpressure, stalls and stray starts.
    for (int k = 0; k < 40; k++) begin
      n    = $urandom_range(0, 12);
      relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) push_word(rand_psum());
      rnd_en = 1'b1;
      do_drain(n, relu, 0);
      rnd_en = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Output-side drain stage for the PE array's output buffer. It pulls a programmed number of partial-sum words from the out-buffer FIFO and saturates each 33-bit signed psum to 16 bits. It optionally applies ReLU, then presents the results on a valid/ready stream with a last marker. A done pulse marks the end of a drain, and a sticky saturation flag records any clipping.

## Interface
- PSUM_WIDTH, 33, signed psum width (IF_SCRATCH_WIDTH + FILT_SCRATCH_WIDTH + 1)
- OUT_WIDTH, 16, signed result width
- CNT_WIDTH, 6, width of the result-count field
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a drain; ignored while busy
- out_count  in  CNT_WIDTH  number of results to drain; sampled on start
- relu_en  in  1  clamp negative results to 0; sampled on start
- outbuf_empty  in  1  out-buffer FIFO empty
- outbuf_ren  out  1  out-buffer read enable
- outbuf_dout  in  PSUM_WIDTH  FIFO data, valid the cycle after outbuf_ren
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts the result
- m_data  out  OUT_WIDTH  saturated (and optionally ReLU'd) result
- m_last  out  1  m_data is the final result of this drain
- busy  out  1  high from accepted start until the final handshake
- done  out  1  one-cycle pulse when a drain completes
- sat_flag  out  1  sticky; set if any result of the current drain clipped

## Operation
- States: IDLE, REQ, CAPT, HOLD.
- **IDLE**
  - start with out_count != 0: latch remaining = out_count and relu_en, clear sat_flag, go to REQ, busy = 1.
  - start with out_count == 0: clear sat_flag, pulse done the next cycle, stay in IDLE, never assert outbuf_ren.
- **REQ**
  - outbuf_ren = (state == REQ) && !outbuf_empty, combinational.
  - If the FIFO is not empty, go to CAPT. Otherwise stay in REQ with no read (empty stall).
- **CAPT**
  - Sample outbuf_dout as signed.
  - Saturate: value > 2^(OUT_WIDTH-1)-1 gives 32767; value < -2^(OUT_WIDTH-1) gives -32768; otherwise take the low OUT_WIDTH bits.
  - Clipping sets sat_flag.
  - ReLU is applied after saturation: if relu_en and the result is negative, the result is 0. ReLU zeroing does not set sat_flag.
  - Register the result into m_data, set m_valid = 1, set m_last = (remaining == 1), go to HOLD.
- **HOLD**
  - m_data and m_last hold stable until m_valid && m_ready.
  - On the handshake: m_valid is cleared and remaining is decremented.
  - If remaining was 1: done pulses and the block returns to IDLE with busy = 0. Otherwise return to REQ.
- At most one FIFO word is in flight. outbuf_ren is never asserted in CAPT or HOLD, so the block never over-reads the FIFO.
- start while busy is ignored; latched parameters do not change mid-drain.
- Reset asserted mid-drain aborts immediately. The state returns to IDLE, and the remaining count and the result register are discarded.

## Timing
- Reset values: outbuf_ren 0, m_valid 0, m_data 0, m_last 0, busy 0, done 0, sat_flag 0, state IDLE.
- start is sampled at edge t; REQ is active in cycle t+1. With the FIFO non-empty, outbuf_ren is high in cycle t+1.
- FIFO data is valid in cycle t+2 (CAPT); m_valid is high from cycle t+3.
- Steady-state throughput with m_ready held high: one result per 3 cycles.
- done is high for exactly the one cycle after the final handshake edge; busy falls in that same cycle.
- sat_flag updates at the end of CAPT and persists after done until the next accepted start.

## Test plan
- **Nominal drain:** out_count=5, relu_en=0; FIFO preloaded with psums -346, 819, -155, -776, 494; m_ready=1 -> m_data sequence 0xFEA6, 0x0333, 0xFF65, 0xFCF8, 0x01EE; m_last only on 494; exactly 5 outbuf_ren pulses; done pulses once; sat_flag=0.
- **Saturation:** psums 40000, -40000, 32767 -> outputs 32767, -32768, 32767; sat_flag=1 after the first result and still 1 after done; the next start clears it.
- **ReLU:** relu_en=1, psums -346, 819 -> outputs 0, 819; sat_flag=0.
- **Backpressure and empty stall:**
  - m_ready low for 4 cycles in HOLD -> m_data/m_last stable, no outbuf_ren.
  - outbuf_empty high for 6 cycles in REQ -> outbuf_ren stays 0 and the read resumes the cycle empty falls.
- **Zero count and ignored start:**
  - out_count=0 -> done the next cycle, no outbuf_ren.
  - start pulsed during a busy 3-result drain -> still exactly 3 results.
- **Reset mid-drain:** rst low during HOLD of result 2 of 5 -> all outputs 0 asynchronously; after release, a new start with out_count=2 drains exactly 2 words.
